// File: rtl/an_code_pkg.sv
// ---------------------------------------------------------------------------
// an_code_pkg
// Shared constants for the 28-bit AN-protected data path. The encoder and
// the decoder both import this package, so they always agree on A and on
// the word widths.
//   A        odd code constant (must stay below 2**A_BITS)
//   A_BITS   width of A, also the number of shift-add iterations
//   N_BITS   data word width
//   W_BITS   codeword width, wide enough that A*N never overflows
// Optional feature macro used by the importers: AN_ERR_INJECT_EN
// ---------------------------------------------------------------------------
package an_code_pkg;

  localparam int unsigned A            = 83;
  localparam int          A_BITS       = 7;
  localparam int          N_BITS       = 29;
  localparam int          W_BITS       = 36;
  localparam int          CNT_BITS     = $clog2(A_BITS);
  localparam int          ERR_POS_BITS = 6;

  // Encoder control states; the top level mirrors these as plain
  // localparam constants for legacy tools.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } an_state_e;

endpackage

// File: rtl/an_encoder_28bits_if.sv
// ---------------------------------------------------------------------------
// an_encoder_28bits_if
// Input and output valid/ready channels of the AN encoder.
//   in_valid / in_ready / N      data word channel (producer -> encoder)
//   out_valid / out_ready / W    codeword channel (encoder -> consumer)
//   err_en / err_neg / err_pos   error-injection controls, present only
//                                when AN_ERR_INJECT_EN is defined
// Modports: master = producer/consumer side, slave = encoder side.
// ---------------------------------------------------------------------------
interface an_encoder_28bits_if;
  import an_code_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] N;
  logic              out_valid;
  logic              out_ready;
  logic [W_BITS-1:0] W;

`ifdef AN_ERR_INJECT_EN
  logic                    err_en;
  logic                    err_neg;
  logic [ERR_POS_BITS-1:0] err_pos;

  modport master (
    output in_valid, N, out_ready, err_en, err_neg, err_pos,
    input  in_ready, out_valid, W
  );

  modport slave (
    input  in_valid, N, out_ready, err_en, err_neg, err_pos,
    output in_ready, out_valid, W
  );
`else
  modport master (
    output in_valid, N, out_ready,
    input  in_ready, out_valid, W
  );

  modport slave (
    input  in_valid, N, out_ready,
    output in_ready, out_valid, W
  );
`endif

endinterface

// File: rtl/an_shift_add_mul.sv
// ---------------------------------------------------------------------------
// an_shift_add_mul
// Sequential shift-add multiplier computing A*N, one bit of A per step,
// LSB first.
//   clk, rst_n   clock and asynchronous active-low reset
//   i_load       latch i_n into the shift register, clear acc and cnt
//   i_step       process bit cnt of A: add nsh if set, shift nsh, cnt++
//   i_n          data word N
//   o_sum        acc plus the addend for the current bit (the final
//                product when o_last is high)
//   o_last       current bit is the last bit of A
// ---------------------------------------------------------------------------
module an_shift_add_mul
  import an_code_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [N_BITS-1:0] i_n,
  output logic [W_BITS-1:0] o_sum,
  output logic              o_last
);

  // A padded to a power-of-two width so every cnt value indexes a real bit,
  // including the parked value cnt reaches after the last step.
  localparam logic [(1 << CNT_BITS)-1:0] A_EXT = A[(1 << CNT_BITS)-1:0];

  logic [W_BITS-1:0]   r_nsh;
  logic [W_BITS-1:0]   r_acc;
  logic [CNT_BITS-1:0] r_cnt;
  logic [W_BITS-1:0]   w_addend;

  assign w_addend = A_EXT[r_cnt] ? r_nsh : '0;
  assign o_sum    = r_acc + w_addend;
  assign o_last   = (r_cnt == CNT_BITS'(A_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nsh <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_nsh <= {{(W_BITS - N_BITS){1'b0}}, i_n};
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= o_sum;
      r_nsh <= r_nsh << 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/an_encoder_28bits.sv
// ---------------------------------------------------------------------------
// an_encoder_28bits
// AN-code encoder: accepts a data word N and returns the codeword W = A*N,
// computed over A_BITS cycles by an_shift_add_mul.
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus          an_encoder_28bits_if.slave (in/out valid-ready channels)
// Optional build macro AN_ERR_INJECT_EN adds err_en/err_neg/err_pos to the
// bus; when enabled and err_pos < W_BITS, +/- 2**err_pos is added to W.
// ---------------------------------------------------------------------------
module an_encoder_28bits
  import an_code_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  an_encoder_28bits_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        r_state;
  logic [W_BITS-1:0] r_W;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [W_BITS-1:0] w_sum;
  logic [W_BITS-1:0] w_final;

  assign w_load = (r_state == S_IDLE) && bus.in_valid;
  assign w_step = (r_state == S_CALC);

  an_shift_add_mul u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_n    (bus.N),
    .o_sum  (w_sum),
    .o_last (w_last)
  );

`ifdef AN_ERR_INJECT_EN
  logic                    r_errEn;
  logic                    r_errNeg;
  logic [ERR_POS_BITS-1:0] r_errPos;
  logic [W_BITS-1:0]       w_errVal;

  // Injection controls travel with the word, so they are captured at the
  // input handshake just like N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errEn  <= 1'b0;
      r_errNeg <= 1'b0;
      r_errPos <= '0;
    end else if (w_load) begin
      r_errEn  <= bus.err_en;
      r_errNeg <= bus.err_neg;
      r_errPos <= bus.err_pos;
    end
  end

  // Positions beyond the codeword width inject nothing.
  always_comb begin
    w_errVal = '0;
    if (r_errEn && (32'(r_errPos) < 32'(W_BITS)))
      w_errVal = {{(W_BITS - 1){1'b0}}, 1'b1} << r_errPos;
  end

  assign w_final = r_errNeg ? (w_sum - w_errVal) : (w_sum + w_errVal);
`else
  assign w_final = w_sum;
`endif

  // Control FSM: the result register is only written on the last multiply
  // step, so W stays frozen through DONE until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_W     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) r_state <= S_CALC;
        S_CALC: begin
          if (w_last) begin
            r_W     <= w_final;
            r_state <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, never the incoming handshakes.
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.W         = r_W;

endmodule

// File: tb/tb_an_encoder_28bits.sv
// ---------------------------------------------------------------------------
// tb_an_encoder_28bits
// Self-checking bench for an_encoder_28bits. Expected codewords are queued
// when a word is driven and compared when the encoder presents W.
// Build with AN_ERR_INJECT_EN defined to also exercise the error injector.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_an_encoder_28bits;
  import an_code_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [W_BITS-1:0] sb[$];

  an_encoder_28bits_if bus();

  an_encoder_28bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid after an acceptance edge, noting whether
  // in_ready was ever seen high meanwhile.
  task automatic waitValid(output int lat, output bit sawReady);
    lat = 0;
    sawReady = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) sawReady = 1'b1;
      tick();
      lat++;
    end
  endtask

  // Drive one word with out_ready high, push its expected W, and wait.
  task automatic runOne(input logic [N_BITS-1:0] n, input logic [W_BITS-1:0] expW,
                        output int lat, output bit sawReady);
    bus.in_valid  = 1'b1;
    bus.N         = n;
    bus.out_ready = 1'b1;
    sb.push_back(expW);
    tick();
    bus.in_valid = 1'b0;
    waitValid(lat, sawReady);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.N = '0;
    bus.out_ready = 1'b0;
`ifdef AN_ERR_INJECT_EN
    bus.err_en = 1'b0;
    bus.err_neg = 1'b0;
    bus.err_pos = '0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.W !== '0) begin errors++; $display("[TB] FAIL reset_W: got %0d expected 0", bus.W); end
  endtask

  task automatic test_basic();
    int lat; bit sawReady; logic [W_BITS-1:0] exp;
    runOne(29'd1, 36'd83, lat, sawReady);
    checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 7", lat); end
    checks++; if (sawReady !== 1'b0) begin errors++; $display("[TB] FAIL basic_in_ready_low: got %0b expected 0", sawReady); end
    exp = sb.pop_front();
    checks++; if (bus.W !== exp) begin errors++; $display("[TB] FAIL basic_W: got %0d expected %0d", bus.W, exp); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_out_valid_drop: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready_back: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_max();
    int lat; bit sawReady; logic [W_BITS-1:0] exp;
    runOne(29'h1FFF_FFFF, 36'd44560285613, lat, sawReady);
    exp = sb.pop_front();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL max_out_valid: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.W !== exp) begin errors++; $display("[TB] FAIL max_W: got %0d expected %0d", bus.W, exp); end
    tick();
  endtask

  task automatic test_stall();
    int lat; bit sawReady; logic [W_BITS-1:0] exp;
    bit bad;
    bus.in_valid  = 1'b1;
    bus.N         = 29'd1000;
    bus.out_ready = 1'b0;
    sb.push_back(36'd83000);
    tick();
    bus.in_valid = 1'b0;
    waitValid(lat, sawReady);
    exp = sb.pop_front();
    checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 7", lat); end
    bus.in_valid = 1'b1;
    bus.N = 29'd5;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.W !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad = 1'b1;
        $display("[TB] stall cycle %0d: W=%0d out_valid=%0b in_ready=%0b", i, bus.W, bus.out_valid, bus.in_ready);
      end
      tick();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold: got unstable=%0b expected 0 (W %0d)", bad, exp); end
    checks++; if (bus.W !== exp) begin errors++; $display("[TB] FAIL stall_W: got %0d expected %0d", bus.W, exp); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_in_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int accT[$];
    int outs;
    logic [W_BITS-1:0] exp;
    bit rdy;
    outs = 0;
    bus.in_valid  = 1'b1;
    bus.N         = 29'd0;
    bus.out_ready = 1'b1;
    sb.push_back(36'd0);
    sb.push_back(36'd1024635);
    for (int i = 0; i < 40 && outs < 2; i++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy && bus.in_valid) begin
        accT.push_back(i);
        if (accT.size() == 1) bus.N = 29'd12345;
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        outs++;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        checks++; if (bus.W !== exp) begin errors++; $display("[TB] FAIL b2b_W%0d: got %0d expected %0d", outs, bus.W, exp); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (outs !== 2) begin errors++; $display("[TB] FAIL b2b_outputs: got %0d expected 2", outs); end
    checks++;
    if (accT.size() !== 2) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d expected 2", accT.size()); end
    else if (accT[1] - accT[0] !== 9) begin errors++; $display("[TB] FAIL b2b_interval: got %0d expected 9", accT[1] - accT[0]); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.in_valid  = 1'b1;
    bus.N         = 29'd77;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.W !== '0) begin errors++; $display("[TB] FAIL midrst_W: got %0d expected 0", bus.W); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %0b expected 1", bus.in_ready); end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_output: got %0b expected 0", seen); end
  endtask

`ifdef AN_ERR_INJECT_EN
  task automatic test_inject();
    int lat; bit sawReady; logic [W_BITS-1:0] exp;
    bus.err_en = 1'b1; bus.err_neg = 1'b0; bus.err_pos = 6'd3;
    runOne(29'd100, 36'd8308, lat, sawReady);
    exp = sb.pop_front();
    checks++; if (bus.W !== exp) begin errors++; $display("[TB] FAIL inj_pos3_W: got %0d expected %0d", bus.W, exp); end
    checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL inj_latency: got %0d expected 7", lat); end
    tick();
    bus.err_en = 1'b1; bus.err_neg = 1'b1; bus.err_pos = 6'd0;
    runOne(29'd0, 36'd68719476735, lat, sawReady);
    exp = sb.pop_front();
    checks++; if (bus.W !== exp) begin errors++; $display("[TB] FAIL inj_neg0_W: got %0d expected %0d", bus.W, exp); end
    tick();
    bus.err_en = 1'b1; bus.err_neg = 1'b0; bus.err_pos = 6'd40;
    runOne(29'd100, 36'd8300, lat, sawReady);
    exp = sb.pop_front();
    checks++; if (bus.W !== exp) begin errors++; $display("[TB] FAIL inj_pos40_W: got %0d expected %0d", bus.W, exp); end
    tick();
    bus.err_en = 1'b0; bus.err_neg = 1'b0; bus.err_pos = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef AN_ERR_INJECT_EN
    test_inject();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
